muldiv_unit: RTL and testbench

- Parametrised, multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Successor to the single-cycle HI/LO arithmetic path in the execute stage.
- Replaces combinational mult/div with an iterative shift-add / restoring-divide datapath and a busy/done handshake.
- Correct signed semantics, divide-by-zero flagging and abort-on-flush.
- Sits beside the ALU in EX; decode stalls HI/LO consumers on busy.

---
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit owning the HI/LO pair
//
// Shift-add multiplier and restoring divider sharing one 2*WIDTH accumulator.
// Signed ops run on magnitudes; the sign fixup is applied at writeback.
//
// Ports:
//   CLK, RESET        clock (rising edge), synchronous active-high reset
//   start, op         request (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO)
//   A, B              operands (A is also the MTHI/MTLO source)
//   flush             abort any in-flight operation, drop a pending start
//   busy              operation in progress
//   done              one-cycle pulse when a mult/div finishes
//   div_by_zero       one-cycle pulse with done when a divide had B == 0
//   HI, LO            architectural HI/LO registers
module muldiv_unit #(
  parameter int WIDTH     = 32,
  parameter bit FAST_MULT = 1'b0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state, state_nxt;
  logic [2*WIDTH-1:0]   acc;       // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]     m;         // multiplicand or divisor magnitude
  logic [CW-1:0]        count;
  logic                 is_div;
  logic                 neg_res;   // product / quotient must be negated
  logic                 neg_rem;   // remainder takes the sign of the dividend
  logic                 b_zero;

  // Request decode. op[2]=0 selects the arithmetic ops; op[0]=0 marks the signed ones.
  logic                 accept;
  logic                 arith;
  logic                 sgn_a, sgn_b;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [2*WIDTH-1:0]   fast_prod;

  assign accept    = (state == IDLE) && start && !flush;
  assign arith     = !op[2];
  assign sgn_a     = !op[0] && A[WIDTH-1];
  assign sgn_b     = !op[0] && B[WIDTH-1];
  assign abs_a     = sgn_a ? -A : A;
  assign abs_b     = sgn_b ? -B : B;
  assign fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};

  // One multiply iteration: conditionally add, then shift the whole accumulator right.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // One restoring-divide iteration: shift in the next dividend bit, subtract if it fits.
  logic [WIDTH:0]       div_shift, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, m};
  assign div_ge    = div_shift >= {1'b0, m};
  assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc[WIDTH-2:0], div_ge};

  // Writeback values. min_int / -1 yields quotient magnitude 2^(WIDTH-1), which wraps on negation.
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        // The fast multiply skips iteration and goes straight to writeback.
        if (accept && arith)
          state_nxt = (FAST_MULT && !op[1]) ? FIX : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (flush)                              state_nxt = IDLE;
        else if (count == CW'(WIDTH - 1))       state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      HI          <= '0;
      LO          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      acc         <= '0;
      m           <= '0;
      count       <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      b_zero      <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (arith) begin
              is_div  <= op[1];
              neg_res <= sgn_a ^ sgn_b;
              neg_rem <= sgn_a;
              b_zero  <= op[1] && (B == '0);
              count   <= '0;
              if (op[1]) begin
                m   <= abs_b;
                acc <= {{WIDTH{1'b0}}, abs_a};
              end else if (FAST_MULT) begin
                acc <= fast_prod;
              end else begin
                m   <= abs_a;
                acc <= {{WIDTH{1'b0}}, abs_b};
              end
            end else if (op == 3'd4) begin
              HI <= A;
            end else if (op == 3'd5) begin
              LO <= A;
            end
          end
        end
        RUN: begin
          if (!flush) begin
            count <= count + 1'b1;
            acc   <= is_div ? div_next : mul_next;
          end
        end
        FIX: begin
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              if (b_zero) div_by_zero <= 1'b1;
              else begin
                HI <= rem_fix;
                LO <= quo_fix;
              end
            end else begin
              {HI, LO} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector bench for muldiv_unit
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        s32, fl32, busy32, done32, dz32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;

  logic        s16, fl16, busy16, done16, dz16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, hi16, lo16;

  muldiv_unit #(.WIDTH(32), .FAST_MULT(1'b0)) u32 (
    .CLK(clk), .RESET(rst), .start(s32), .op(op32), .A(a32), .B(b32), .flush(fl32),
    .busy(busy32), .done(done32), .div_by_zero(dz32), .HI(hi32), .LO(lo32)
  );

  muldiv_unit #(.WIDTH(16), .FAST_MULT(1'b1)) u16 (
    .CLK(clk), .RESET(rst), .start(s16), .op(op16), .A(a16), .B(b16), .flush(fl16),
    .busy(busy16), .done(done16), .div_by_zero(dz16), .HI(hi16), .LO(lo16)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents a request for one edge; returns at the falling edge after the accepting edge.
  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    s32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(negedge clk);
    s32 = 1'b0;
  endtask

  task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    s16 = 1'b1; op16 = op; a16 = a; b16 = b;
    @(negedge clk);
    s16 = 1'b0;
  endtask

  // Counts falling edges until done; -1 if the bound expires.
  task automatic wait32(input int start_cyc, output int cyc);
    cyc = start_cyc;
    while (!done32 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!done32) cyc = -1;
  endtask

  task automatic wait16(output int cyc);
    cyc = 0;
    while (!done16 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!done16) cyc = -1;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[8];
  int   cyc;
  int   dones;

  initial begin
    vecs[0] = '{"mult_neg2x3",   3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{"multu_fffe_x3", 3'd1, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
    vecs[2] = '{"mult_max_sq",   3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[3] = '{"mult_m1_m1",    3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[4] = '{"div_m7_2",      3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[5] = '{"divu_100_7",    3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6] = '{"div_min_m1",    3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7] = '{"div_7_m2",      3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

    rst = 1'b1;
    s32 = 1'b0; op32 = '0; a32 = '0; b32 = '0; fl32 = 1'b0;
    s16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; fl16 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_hi",   hi32,   0);
    check("reset_lo",   lo32,   0);
    check("reset_busy", busy32, 0);
    check("reset_done", done32, 0);
    check("reset_dz",   dz32,   0);

    for (int i = 0; i < 8; i++) begin
      issue32(vecs[i].op, vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_busy"}, busy32, 1);
      wait32(0, cyc);
      check({vecs[i].name, "_latency"}, 64'(cyc), 33);
      check({vecs[i].name, "_hi"}, hi32, vecs[i].hi);
      check({vecs[i].name, "_lo"}, lo32, vecs[i].lo);
      check({vecs[i].name, "_dz"}, dz32, 0);
      @(negedge clk);
      check({vecs[i].name, "_done_pulse"}, done32, 0);
    end

    // Reset ten cycles into a divide clears HI/LO and suppresses done.
    issue32(3'd3, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_hi",   hi32,   0);
    check("rst_mid_lo",   lo32,   0);
    check("rst_mid_busy", busy32, 0);
    dones = 0;
    repeat (40) begin @(negedge clk); if (done32) dones++; end
    check("rst_mid_no_done", 64'(dones), 0);

    // Divide by zero keeps preloaded HI/LO; starts during busy are ignored.
    issue32(3'd4, 32'h11, 32'h0);
    check("mthi_hi", hi32, 32'h11);
    issue32(3'd5, 32'h22, 32'h0);
    check("mtlo_lo", lo32, 32'h22);
    check("mtlo_done", done32, 0);
    issue32(3'd3, 32'd5, 32'd0);
    s32 = 1'b1; op32 = 3'd5; a32 = 32'h5555;
    @(negedge clk);
    op32 = 3'd0; a32 = 32'd3; b32 = 32'd3;
    @(negedge clk);
    s32 = 1'b0;
    check("busy_mtlo_ignored", lo32, 32'h22);
    wait32(2, cyc);
    check("dz_latency", 64'(cyc), 33);
    check("dz_flag",    dz32,    1);
    check("dz_hi",      hi32,    32'h11);
    check("dz_lo",      lo32,    32'h22);
    @(negedge clk);
    check("dz_pulse_end", dz32, 0);

    // Flush five cycles into a divide.
    issue32(3'd2, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    fl32 = 1'b1;
    @(negedge clk);
    fl32 = 1'b0;
    check("flush_busy", busy32, 0);
    dones = 0;
    repeat (40) begin @(negedge clk); if (done32) dones++; end
    check("flush_no_done", 64'(dones), 0);
    check("flush_hi", hi32, 32'h11);
    check("flush_lo", lo32, 32'h22);

    // Flush with a start in IDLE drops the start.
    @(negedge clk);
    s32 = 1'b1; op32 = 3'd5; a32 = 32'h7777; fl32 = 1'b1;
    @(negedge clk);
    s32 = 1'b0; fl32 = 1'b0;
    check("flush_start_lo",   lo32,   32'h22);
    check("flush_start_busy", busy32, 0);

    issue32(3'd5, 32'hABCD, 32'h0);
    check("mtlo_abcd_lo",   lo32,   32'hABCD);
    check("mtlo_abcd_hi",   hi32,   32'h11);
    check("mtlo_abcd_done", done32, 0);
    check("mtlo_abcd_busy", busy32, 0);

    // Reserved op leaves everything alone.
    issue32(3'd6, 32'h9999, 32'h9999);
    check("rsvd_busy", busy32, 0);
    check("rsvd_hi",   hi32,   32'h11);
    check("rsvd_lo",   lo32,   32'hABCD);

    // Fast 16-bit multiply with back-to-back acceptance on the done cycle.
    issue16(3'd0, 16'h8000, 16'h8000);
    wait16(cyc);
    check("fast_latency", 64'(cyc), 1);
    check("fast_hi", hi16, 16'h4000);
    check("fast_lo", lo16, 16'h0000);
    s16 = 1'b1; op16 = 3'd1; a16 = 16'hFFFF; b16 = 16'hFFFF;
    @(negedge clk);
    s16 = 1'b0;
    check("b2b_busy", busy16, 1);
    check("b2b_done_low", done16, 0);
    @(negedge clk);
    check("b2b_done", done16, 1);
    check("b2b_hi", hi16, 16'hFFFE);
    check("b2b_lo", lo16, 16'h0001);
    @(negedge clk);
    check("b2b_busy_end", busy16, 0);

    // Divides on the fast-multiply build keep iterative latency.
    issue16(3'd2, 16'hFFF9, 16'h0002);
    wait16(cyc);
    check("fast_div_latency", 64'(cyc), 17);
    check("fast_div_hi", hi16, 16'hFFFF);
    check("fast_div_lo", lo16, 16'hFFFD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
